// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: tracks the EX/MEM producers,
// registers per-operand forward words, raises load-use stall and redirect squash.
module hazard_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic             id_rs_used,
  input  logic [2:0]       id_rt,
  input  logic             id_rt_used,
  input  logic             id_is_store,
  input  logic             id_wr_en,
  input  logic [2:0]       id_wr_reg,
  input  logic [1:0]       id_wb_src,
  input  logic             ex_redirect,
  output logic [4:0]       fwCntrlA,
  output logic [4:0]       fwCntrlB,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_OPS = 2;
  localparam logic [1:0] WB_MEM = 2'b01;

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [2:0] rd;
    logic [1:0] wb_src;
  } slot_t;

  slot_t ex_slot, mem_slot, id_entry;

  logic [NUM_OPS-1:0]      op_used;
  logic [NUM_OPS-1:0][2:0] op_reg;
  logic [NUM_OPS-1:0][3:0] fw;
  logic [NUM_OPS-1:0]      load_hit;

  assign op_used = {id_rt_used, id_rs_used};
  assign op_reg  = {id_rt, id_rs};

  // Operand 0 is rs (word A), operand 1 is rt (word B / store data).
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    logic hit_ex, hit_mem;
    assign hit_ex  = op_used[i] && ex_slot.valid && ex_slot.wr_en && (ex_slot.rd == op_reg[i]);
    assign hit_mem = op_used[i] && mem_slot.valid && mem_slot.wr_en && (mem_slot.rd == op_reg[i]);
    assign load_hit[i] = hit_ex && (ex_slot.wb_src == WB_MEM);
    always_comb begin
      fw[i] = 4'b0000;
      if (hit_ex)       fw[i] = {2'b10, ex_slot.wb_src};
      else if (hit_mem) fw[i] = {2'b11, mem_slot.wb_src};
    end
  end

  // Redirect wins over load-use: the consumer is squashed anyway.
  assign stall = id_valid && !ex_redirect && (|load_hit);

  always_comb begin
    id_entry        = '0;
    id_entry.valid  = id_valid && !stall && !ex_redirect;
    id_entry.wr_en  = id_wr_en;
    id_entry.rd     = id_wr_reg;
    id_entry.wb_src = id_wb_src;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      fwCntrlA  <= '0;
      fwCntrlB  <= '0;
      bubble    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      mem_slot <= ex_slot;
      ex_slot  <= id_entry;
      fwCntrlA <= id_entry.valid ? {1'b0, fw[0]} : 5'b00000;
      fwCntrlB <= id_entry.valid ? {id_is_store, fw[1]} : 5'b00000;
      bubble   <= stall || ex_redirect;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding priority, load-use, redirect, freeze, saturation.
module tb_hazard_fwd_ctrl;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst, freeze, id_valid, id_rs_used, id_rt_used, id_is_store, id_wr_en, ex_redirect;
  logic [2:0]       id_rs, id_rt, id_wr_reg;
  logic [1:0]       id_wb_src;
  logic [4:0]       fwCntrlA, fwCntrlB;
  logic             stall, bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_is_store(id_is_store), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_wb_src(id_wb_src), .ex_redirect(ex_redirect),
    .fwCntrlA(fwCntrlA), .fwCntrlB(fwCntrlB), .stall(stall), .bubble(bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu, input logic st,
                        input logic we, input logic [2:0] wr, input logic [1:0] wb);
    id_valid = v;  id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_is_store = st; id_wr_en = we; id_wr_reg = wr; id_wb_src = wb;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    // Reset dominates freeze/redirect with everything toggling.
    for (int i = 0; i < 4; i++) begin
      freeze = 1'($urandom); ex_redirect = 1'($urandom);
      set_id(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
      tick();
    end
    chk("rst_fwA", fwCntrlA, 0);
    chk("rst_fwB", fwCntrlB, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    rst = 1'b1; freeze = 1'b0; ex_redirect = 1'b0;

    // ADD R3 <- R1,R2 (ALU); slots empty so no forwarding, no stall.
    set_id(1, 1, 1, 2, 1, 0, 1, 3, 2'b10);
    #1 chk("rst_stall", stall, 0);
    tick();
    chk("add_r1_fwA", fwCntrlA, 5'b00000);
    chk("add_r1_fwB", fwCntrlB, 5'b00000);

    // ADD R6 <- R3: X2X from ALU.
    set_id(1, 3, 1, 0, 0, 0, 1, 6, 2'b10);
    tick();
    chk("x2x_fwA", fwCntrlA, 5'b01010);

    // Independent ADD R7 <- R7.
    set_id(1, 7, 1, 0, 0, 0, 1, 7, 2'b10);
    tick();
    chk("indep_fwA", fwCntrlA, 5'b00000);

    // Reads R6, produced two ahead: M2X.
    set_id(1, 6, 1, 0, 0, 0, 1, 4, 2'b10);
    tick();
    chk("m2x_fwA", fwCntrlA, 5'b01110);

    // LD R2 then consumer of R2 via rt: one-cycle load-use stall.
    set_id(1, 5, 0, 0, 0, 0, 1, 2, 2'b01);
    tick();
    set_id(1, 0, 0, 2, 1, 0, 1, 1, 2'b10);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", bubble, 1);
    chk("lu_bubble_fwB", fwCntrlB, 5'b00000);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_released", stall, 0);
    tick();
    chk("lu_fwB", fwCntrlB, 5'b01101);
    chk("lu_bubble_clr", bubble, 0);
    chk("lu_stall_cnt_hold", stall_cnt, 1);

    // LBI R4 (imm8), ADD R4 (ALU), consumer of R4: youngest producer wins.
    set_id(1, 0, 0, 0, 0, 0, 1, 4, 2'b11);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 4, 2'b10);
    tick();
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 2'b00);
    tick();
    chk("prio_fwA", fwCntrlA, 5'b01010);

    // SLBI R5 (imm8), then ST with data register R5.
    set_id(1, 0, 0, 0, 0, 0, 1, 5, 2'b11);
    tick();
    set_id(1, 4, 1, 5, 1, 1, 0, 0, 2'b00);
    tick();
    chk("st_fwB", fwCntrlB, 5'b11011);
    chk("st_fwA", fwCntrlA, 5'b00000);

    // R0 has no exemption.
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 2'b10);
    tick();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    tick();
    chk("r0_fwA", fwCntrlA, 5'b01010);
    chk("r0_fwB_store_clr", fwCntrlB, 5'b00000);

    // Load-use coinciding with redirect: squash, not stall.
    set_id(1, 0, 0, 0, 0, 0, 1, 3, 2'b01);
    tick();
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 2'b00);
    ex_redirect = 1'b1;
    #1 chk("redir_stall", stall, 0);
    tick();
    chk("redir_bubble", bubble, 1);
    chk("redir_fwA", fwCntrlA, 5'b00000);
    chk("redir_flush_cnt", flush_cnt, 1);
    chk("redir_stall_cnt", stall_cnt, 1);
    // Load advanced to MEM despite the redirect: refetched consumer gets M2X, no stall.
    ex_redirect = 1'b0;
    #1 chk("redir_mem_nostall", stall, 0);
    tick();
    chk("redir_mem_fwA", fwCntrlA, 5'b01101);
    chk("redir_mem_bubble", bubble, 0);

    // Freeze for 3 cycles while a load-use stall is pending.
    set_id(1, 0, 0, 0, 0, 0, 1, 6, 2'b01);
    tick();
    set_id(1, 0, 0, 6, 1, 0, 0, 0, 2'b00);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_stall", stall, 1);
      chk("frz_stall_cnt", stall_cnt, 1);
      chk("frz_bubble", bubble, 0);
    end
    chk("frz_flush_cnt", flush_cnt, 1);
    freeze = 1'b0;
    tick();
    chk("frz_rel_bubble", bubble, 1);
    chk("frz_rel_stall_cnt", stall_cnt, 2);
    tick();
    chk("frz_rel_fwB", fwCntrlB, 5'b01101);

    // Flush counter saturates at all-ones.
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    ex_redirect = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_flush_top", flush_cnt, 7);
    tick();
    tick();
    chk("sat_flush_hold", flush_cnt, 7);
    chk("sat_stall_cnt", stall_cnt, 2);
    ex_redirect = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core; sits alongside the ID/EX pipeline register.
- Tracks destination-register and writeback-source info for the instructions in EX and MEM.
- Produces the 5-bit forwarding control words consumed by the execute stage, load-use stall/bubble, and branch-redirect squash, plus saturating stall/flush event counters.

Parameters:
- CNT_W, 16, width of stall and flush event counters (saturating).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- freeze  in  1  global hold from memory stall; all state holds when 1
- id_valid  in  1  ID holds a real instruction
- id_rs  in  3  source register A
- id_rs_used  in  1  instruction reads rs
- id_rt  in  3  source register B / store data register
- id_rt_used  in  1  instruction reads rt
- id_is_store  in  1  ST/STU; becomes fwCntrlB[4]
- id_wr_en  in  1  instruction writes the register file
- id_wr_reg  in  3  destination register
- id_wb_src  in  2  writeback source: 00 addPC, 01 mem, 10 ALU, 11 imm8
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- fwCntrlA  out  5  registered forward word for operand A; bit 4 always 0
- fwCntrlB  out  5  registered forward word for operand B/store data
- stall  out  1  combinational; hold PC and IF/ID
- bubble  out  1  registered; EX slot holds a bubble this cycle
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  redirect squashes, saturating

Behaviour:
- Reset (rst==0 at posedge): EX and MEM tracking slots invalid; fwCntrlA/B=0; bubble=0; counters=0. Reset overrides freeze and redirect.
- Tracking slot fields: valid, wr_en, reg[2:0], wb_src[1:0]. Advance at each posedge with freeze==0: MEM<=EX; EX<=ID-derived entry. The entry is invalid if stall, ex_redirect or !id_valid.
- Forward word format: [4] store flag, [3] forward enable, [2] 0=X2X (producer one ahead) / 1=M2X (producer two ahead), [1:0] the producer's wb_src.
- Match per operand: operand used && slot.valid && slot.wr_en && slot.reg==operand reg. R0 is a real register; there is no R0 exemption.
- Priority: EX-slot match yields X2X, computed from the current EX slot, and takes precedence over a MEM-slot match. MEM-slot match yields M2X. No match gives [3:0]=0.
- Load-use: stall=1 when id_valid && !ex_redirect && an operand matches the EX slot with wb_src==01. The stall is held until the next non-frozen edge.
  - At that edge an invalid entry (bubble) enters EX. fwCntrlA/B<=0 and bubble<=1.
  - The next cycle the load sits in MEM, giving M2X with [1:0]=01. No second stall occurs.
- fwCntrlB[4] <= id_is_store whenever a valid entry is latched, and 0 for bubbles.
- ex_redirect=1 takes priority over stall: the ID instruction is squashed (bubble latched, stall=0) and flush_cnt increments.
- The MEM slot still advances on redirect; an older instruction past EX completes normally.
- freeze=1: all registers hold and stall is still driven. Counters hold.
- stall_cnt increments on each non-frozen edge with stall=1. Both counters saturate at all-ones.
- Latency: forward words are valid in the cycle the instruction is in EX, one clock after ID.

Test Plan:
- Reset with all inputs toggling, then release: outputs 0, slots invalid, stall=0; an ADD reading R1 gets fwCntrlA=0.
- ADD R3<-(ALU), next ADD reads R3 as rs: next cycle fwCntrlA=5'b01010. Inserting one independent instr between them gives fwCntrlA=5'b01110.
- LD R2, next instr reads R2 as rt: stall=1 for exactly one cycle, bubble=1, stall_cnt=1. Then fwCntrlB=5'b01101.
- Both EX and MEM slots write R4 (LBI then ADD): consumer of R4 gets X2X from the ADD, fwCntrlA=5'b01010.
- ST with data register R5 just written by SLBI (imm8 source, 11): fwCntrlB=5'b11011.
- Load-use stall coinciding with ex_redirect=1: stall=0, bubble latched, flush_cnt=1, stall_cnt unchanged.
- freeze held for 3 cycles during a stall: stall stays 1 and the counters do not advance.
